// File: rtl/note_voice_scheduler.sv
// Polyphonic voice allocator: scans the key levels one per cycle, assigns new presses to
// tone-generator voices (stealing the oldest when full) and frees voices on release.
module note_voice_scheduler #(
  parameter int NUM_KEYS   = 10,
  parameter int NUM_VOICES = 4,
  parameter int DELAY_W    = 17
) (
  input  logic                          CLOCK_50,
  input  logic                          resetn,
  input  logic [NUM_KEYS-1:0]           keys,
  output logic [NUM_VOICES-1:0]         voice_active,
  output logic [4*NUM_VOICES-1:0]       voice_key,
  output logic [DELAY_W*NUM_VOICES-1:0] voice_delay,
  output logic [NUM_VOICES-1:0]         voice_start,
  output logic                          steal
);

  localparam logic [3:0] LAST_K  = 4'(NUM_KEYS - 1);
  localparam logic [2:0] AGE_MAX = 3'(NUM_VOICES - 1);

  logic [3:0]          scan_k;
  logic [NUM_KEYS-1:0] prev;
  logic [3:0]          key_r   [NUM_VOICES];
  logic [DELAY_W-1:0]  delay_r [NUM_VOICES];
  logic [2:0]          age     [NUM_VOICES];

  logic       cur_lvl, prev_lvl, rise, fall;
  logic       held, any_free, do_alloc;
  logic [2:0] free_idx, old_idx, old_age, alloc_idx;

  function automatic logic [DELAY_W-1:0] note_delay(input logic [3:0] k);
    case (k)
      4'd0:    note_delay = DELAY_W'(95555);
      4'd1:    note_delay = DELAY_W'(85132);
      4'd2:    note_delay = DELAY_W'(75843);
      4'd3:    note_delay = DELAY_W'(71586);
      4'd4:    note_delay = DELAY_W'(63776);
      4'd5:    note_delay = DELAY_W'(56818);
      4'd6:    note_delay = DELAY_W'(50619);
      4'd7:    note_delay = DELAY_W'(47778);
      4'd8:    note_delay = DELAY_W'(42566);
      4'd9:    note_delay = DELAY_W'(37922);
      default: note_delay = '0;
    endcase
  endfunction

  assign cur_lvl  = keys[scan_k];
  assign prev_lvl = prev[scan_k];
  assign rise     = cur_lvl & ~prev_lvl;
  assign fall     = ~cur_lvl & prev_lvl;

  // Descending walk: the last hit wins, giving lowest free index and lowest index on age ties.
  always_comb begin
    held     = 1'b0;
    any_free = 1'b0;
    free_idx = '0;
    old_idx  = '0;
    old_age  = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (voice_active[v] && key_r[v] == scan_k) held = 1'b1;
      if (!voice_active[v]) begin
        any_free = 1'b1;
        free_idx = 3'(v);
      end
      if (age[v] >= old_age) begin
        old_age = age[v];
        old_idx = 3'(v);
      end
    end
    alloc_idx = any_free ? free_idx : old_idx;
    do_alloc  = rise & ~held;
  end

  always_comb begin
    voice_key   = '0;
    voice_delay = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_key[4*v +: 4]             = key_r[v];
      voice_delay[DELAY_W*v +: DELAY_W] = delay_r[v];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      scan_k       <= '0;
      prev         <= '0;
      voice_active <= '0;
      voice_start  <= '0;
      steal        <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_r[v]   <= '0;
        delay_r[v] <= '0;
        age[v]     <= '0;
      end
    end else begin
      voice_start    <= '0;
      steal          <= 1'b0;
      prev[scan_k]   <= cur_lvl;
      scan_k         <= (scan_k == LAST_K) ? 4'd0 : scan_k + 4'd1;
      if (do_alloc) begin
        steal <= ~any_free;
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (3'(v) == alloc_idx) begin
            voice_active[v] <= 1'b1;
            key_r[v]        <= scan_k;
            delay_r[v]      <= note_delay(scan_k);
            age[v]          <= '0;
            voice_start[v]  <= 1'b1;
          end else if (voice_active[v] && age[v] != AGE_MAX) begin
            age[v] <= age[v] + 3'd1;
          end
        end
      end else if (fall) begin
        // Key and delay are kept so the generator can ramp down on stale values.
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (key_r[v] == scan_k) voice_active[v] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_voice_scheduler.sv
// Directed bench for note_voice_scheduler: press/release, fill, steal, reuse,
// simultaneous presses and asynchronous reset during activity.
module tb_note_voice_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic [9:0]  keys     = '0;
  logic [3:0]  voice_active;
  logic [15:0] voice_key;
  logic [67:0] voice_delay;
  logic [3:0]  voice_start;
  logic        steal;

  int errors = 0;
  int checks = 0;

  int start_cnt = 0;
  int steal_cnt = 0;
  int coinc_cnt = 0;
  int alloc_v[$];
  int alloc_k[$];

  note_voice_scheduler dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .keys        (keys),
    .voice_active(voice_active),
    .voice_key   (voice_key),
    .voice_delay (voice_delay),
    .voice_start (voice_start),
    .steal       (steal)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    start_cnt += $countones(voice_start);
    if (steal) steal_cnt++;
    if (steal && voice_start == 4'b0001) coinc_cnt++;
    if ($countones(voice_start) == 1) begin
      for (int v = 0; v < 4; v++) begin
        if (voice_start[v]) begin
          alloc_v.push_back(v);
          alloc_k.push_back(int'(voice_key[4*v +: 4]));
        end
      end
    end
  end

  function automatic logic [3:0] vkey(input int v);
    return voice_key[4*v +: 4];
  endfunction

  function automatic logic [16:0] vdel(input int v);
    return voice_delay[17*v +: 17];
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic test_reset;
    @(negedge CLOCK_50);
    resetn = 1'b0;
    keys   = '0;
    wait_cycles(2);
    checks++; if (voice_active !== 4'h0) begin errors++; $display("FAIL reset_active got=%h exp=0", voice_active); end
    checks++; if (voice_key !== 16'h0) begin errors++; $display("FAIL reset_key got=%h exp=0", voice_key); end
    checks++; if (voice_delay !== 68'h0) begin errors++; $display("FAIL reset_delay got=%h exp=0", voice_delay); end
    checks++; if (voice_start !== 4'h0) begin errors++; $display("FAIL reset_start got=%h exp=0", voice_start); end
    checks++; if (steal !== 1'b0) begin errors++; $display("FAIL reset_steal got=%b exp=0", steal); end
    resetn = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_single;
    int s0, st0;
    s0 = start_cnt; st0 = steal_cnt;
    keys = 10'b0000100000;
    for (int i = 0; i < 12 && voice_active == 4'h0; i++) @(negedge CLOCK_50);
    checks++; if (voice_active !== 4'b0001) begin errors++; $display("FAIL single_active got=%b exp=0001", voice_active); end
    checks++; if (vkey(0) !== 4'd5) begin errors++; $display("FAIL single_key got=%0d exp=5", vkey(0)); end
    checks++; if (vdel(0) !== 17'd56818) begin errors++; $display("FAIL single_delay got=%0d exp=56818", vdel(0)); end
    wait_cycles(2);
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL single_starts got=%0d exp=1", start_cnt - s0); end
    checks++; if (steal_cnt - st0 !== 0) begin errors++; $display("FAIL single_steal got=%0d exp=0", steal_cnt - st0); end
    s0 = start_cnt;
    keys = '0;
    for (int i = 0; i < 12 && voice_active != 4'h0; i++) @(negedge CLOCK_50);
    checks++; if (voice_active !== 4'h0) begin errors++; $display("FAIL release_active got=%b exp=0000", voice_active); end
    wait_cycles(2);
    checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL release_starts got=%0d exp=0", start_cnt - s0); end
  endtask

  task automatic test_fill;
    int ek[4] = '{0, 2, 4, 6};
    int ed[4] = '{95555, 75843, 63776, 50619};
    int st0;
    st0 = steal_cnt;
    for (int i = 0; i < 4; i++) begin
      keys[ek[i]] = 1'b1;
      wait_cycles(20);
    end
    checks++; if (voice_active !== 4'hF) begin errors++; $display("FAIL fill_active got=%h exp=F", voice_active); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (vkey(i) !== 4'(ek[i])) begin errors++; $display("FAIL fill_key%0d got=%0d exp=%0d", i, vkey(i), ek[i]); end
      checks++; if (vdel(i) !== 17'(ed[i])) begin errors++; $display("FAIL fill_delay%0d got=%0d exp=%0d", i, vdel(i), ed[i]); end
    end
    checks++; if (steal_cnt - st0 !== 0) begin errors++; $display("FAIL fill_steal got=%0d exp=0", steal_cnt - st0); end
  endtask

  task automatic test_steal;
    int st0, c0;
    st0 = steal_cnt; c0 = coinc_cnt;
    keys[9] = 1'b1;
    wait_cycles(20);
    checks++; if (vkey(0) !== 4'd9) begin errors++; $display("FAIL steal_key got=%0d exp=9", vkey(0)); end
    checks++; if (vdel(0) !== 17'd37922) begin errors++; $display("FAIL steal_delay got=%0d exp=37922", vdel(0)); end
    checks++; if (steal_cnt - st0 !== 1) begin errors++; $display("FAIL steal_count got=%0d exp=1", steal_cnt - st0); end
    checks++; if (coinc_cnt - c0 !== 1) begin errors++; $display("FAIL steal_with_start0 got=%0d exp=1", coinc_cnt - c0); end
    keys[0] = 1'b0;
    wait_cycles(20);
    checks++; if (voice_active !== 4'hF) begin errors++; $display("FAIL evicted_release got=%h exp=F", voice_active); end
  endtask

  task automatic test_reuse;
    int st0;
    st0 = steal_cnt;
    keys[4] = 1'b0;
    wait_cycles(20);
    checks++; if (voice_active !== 4'b1011) begin errors++; $display("FAIL reuse_free got=%b exp=1011", voice_active); end
    keys[7] = 1'b1;
    wait_cycles(20);
    checks++; if (vkey(2) !== 4'd7) begin errors++; $display("FAIL reuse_key got=%0d exp=7", vkey(2)); end
    checks++; if (vdel(2) !== 17'd47778) begin errors++; $display("FAIL reuse_delay got=%0d exp=47778", vdel(2)); end
    checks++; if (steal_cnt - st0 !== 0) begin errors++; $display("FAIL reuse_steal got=%0d exp=0", steal_cnt - st0); end
  endtask

  task automatic test_back_to_back;
    int s0, q0;
    int ev[3] = '{0, 1, 2};
    int ekk[3] = '{0, 1, 9};
    @(negedge CLOCK_50);
    resetn = 1'b0;
    keys   = '0;
    wait_cycles(2);
    s0 = start_cnt; q0 = alloc_v.size();
    keys   = 10'b1000000011;
    resetn = 1'b1;
    wait_cycles(15);
    checks++; if (start_cnt - s0 !== 3) begin errors++; $display("FAIL simul_starts got=%0d exp=3", start_cnt - s0); end
    checks++; if (alloc_v.size() - q0 !== 3) begin errors++; $display("FAIL simul_onehot_pulses got=%0d exp=3", alloc_v.size() - q0); end
    for (int i = 0; i < 3 && q0 + i < alloc_v.size(); i++) begin
      checks++; if (alloc_v[q0+i] !== ev[i] || alloc_k[q0+i] !== ekk[i]) begin
        errors++; $display("FAIL simul_order%0d got=v%0d/k%0d exp=v%0d/k%0d", i, alloc_v[q0+i], alloc_k[q0+i], ev[i], ekk[i]);
      end
    end
    checks++; if (vdel(1) !== 17'd85132) begin errors++; $display("FAIL simul_delay1 got=%0d exp=85132", vdel(1)); end
  endtask

  task automatic test_async_reset;
    int st0;
    keys = 10'h3FF;
    wait_cycles(25);
    @(negedge CLOCK_50);
    #2 resetn = 1'b0;
    #1;
    checks++; if (voice_active !== 4'h0 || voice_start !== 4'h0 || steal !== 1'b0) begin
      errors++; $display("FAIL async_ctrl got=%b/%b/%b exp=0/0/0", voice_active, voice_start, steal);
    end
    checks++; if (voice_key !== 16'h0 || voice_delay !== 68'h0) begin
      errors++; $display("FAIL async_data got=%h/%h exp=0/0", voice_key, voice_delay);
    end
    wait_cycles(3);
    st0 = steal_cnt;
    resetn = 1'b1;
    for (int i = 0; i < 12 && voice_active != 4'hF; i++) @(negedge CLOCK_50);
    checks++; if (voice_active !== 4'hF) begin errors++; $display("FAIL async_refill got=%h exp=F", voice_active); end
    for (int v = 0; v < 4; v++) begin
      checks++; if (vkey(v) !== 4'(v)) begin errors++; $display("FAIL async_key%0d got=%0d exp=%0d", v, vkey(v), v); end
    end
    checks++; if (steal_cnt - st0 !== 0) begin errors++; $display("FAIL async_early_steal got=%0d exp=0", steal_cnt - st0); end
    @(negedge CLOCK_50);
    checks++; if (steal !== 1'b1 || voice_start !== 4'b0001) begin
      errors++; $display("FAIL async_key4_steal got=%b/%b exp=1/0001", steal, voice_start);
    end
    checks++; if (vkey(0) !== 4'd4) begin errors++; $display("FAIL async_key4_owner got=%0d exp=4", vkey(0)); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_single;
    test_fill;
    test_steal;
    test_reuse;
    test_back_to_back;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
